// File: rtl/apb_master_requester.sv
// APB4 requester: turns single-beat valid/ready commands into APB
// SETUP/ACCESS transfers and returns status on a valid/ready response port.
module apb_master_requester #(
  parameter  int N = 32,
  parameter  int A = 10,
  parameter  int B = N / 8,
  parameter  int O = 1,
  parameter  int T = 16,
  localparam int S = (O > 1) ? $clog2(O) : 1
) (
  input  logic         pclk,
  input  logic         presetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [A-1:0] cmd_addr,
  input  logic         cmd_write,
  input  logic [N-1:0] cmd_wdata,
  input  logic [B-1:0] cmd_strb,
  input  logic [2:0]   cmd_prot,
  input  logic [S-1:0] cmd_sel,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_slverr,
  output logic         rsp_timeout,
  output logic [A-1:0] paddr,
  output logic [2:0]   pprot,
  output logic [O-1:0] pselx,
  output logic         penable,
  output logic         pwrite,
  output logic [N-1:0] pwdata,
  output logic [B-1:0] pstrb,
  input  logic         pready,
  input  logic [N-1:0] prdata,
  input  logic         pslverr
);

  localparam int CW = (T > 0) ? $clog2(T + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [S:0]    LP_O = (S + 1)'(O);
  localparam logic [CW-1:0] LP_T = CW'(T);

  logic [1:0]    r_state;
  logic [A-1:0]  r_addr;
  logic          r_write;
  logic [N-1:0]  r_wdata;
  logic [B-1:0]  r_strb;
  logic [2:0]    r_prot;
  logic [S-1:0]  r_sel;
  logic [CW-1:0] r_wait;
  logic [N-1:0]  r_rdata;
  logic          r_slverr;
  logic          r_timeout;

  logic w_sel_ok;
  logic w_active;
  logic w_timeout;

  assign w_sel_ok  = ({1'b0, cmd_sel} < LP_O);
  assign w_active  = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign w_timeout = (T > 0) && !pready && (r_wait == LP_T);

  // Transfer FSM, command capture, wait counter and response capture.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_prot    <= '0;
      r_sel     <= '0;
      r_wait    <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr    <= cmd_addr;
            r_write   <= cmd_write;
            // Read-side data/strobes are stored as zero so the bus shows 0.
            r_wdata   <= cmd_write ? cmd_wdata : '0;
            r_strb    <= cmd_write ? cmd_strb  : '0;
            r_prot    <= cmd_prot;
            r_sel     <= cmd_sel;
            r_wait    <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            if (w_sel_ok) begin
              r_slverr <= 1'b0;
              r_state  <= ST_SETUP;
            end else begin
              r_slverr <= 1'b1;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            r_slverr <= pslverr;
            r_rdata  <= (!r_write && !pslverr) ? prdata : '0;
            r_state  <= ST_RESP;
          end else if (w_timeout) begin
            r_slverr  <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-hot completer select, live only during SETUP and ACCESS.
  always_comb begin
    pselx = '0;
    for (int unsigned i = 0; i < O; i++) begin
      pselx[i] = w_active && (r_sel == S'(i));
    end
  end

  // cmd_ready is gated by presetn so it reads 0 while reset is held.
  assign cmd_ready   = presetn && (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_slverr  = r_slverr;
  assign rsp_timeout = r_timeout;

  assign penable = (r_state == ST_ACCESS);
  assign paddr   = w_active ? r_addr  : '0;
  assign pprot   = w_active ? r_prot  : '0;
  assign pwrite  = w_active ? r_write : 1'b0;
  assign pwdata  = w_active ? r_wdata : '0;
  assign pstrb   = w_active ? r_strb  : '0;

endmodule

// File: doc/apb_master_requester.md
Name: apb_master_requester

Overview:
APB4 requester: converts single-beat commands from a valid/ready command port into APB SETUP/ACCESS transfers toward one of O completers (e.g. APBSlaveMemory instances).
Returns read data, error and timeout status on a valid/ready response port.
Used as the RTL initiator in front of APB completer subsystems and as the DUT-side driver in APB unit benches.

Parameters:
N, 32, data bus width in bits (8, 16 or 32).
A, 10, address width in bits.
B, N/8, number of byte lanes (width of pstrb).
O, 1, number of completers (width of pselx).
S, (O>1 ? $clog2(O) : 1), width of cmd_sel; derived, not overridden.
T, 16, ACCESS wait-cycle timeout limit; 0 disables the timeout.

Ports:
pclk  in  1  clock; all logic on rising edge.
presetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_addr  in  A  transfer address.
cmd_write  in  1  1=write, 0=read.
cmd_wdata  in  N  write data.
cmd_strb  in  B  write byte strobes.
cmd_prot  in  3  protection attributes.
cmd_sel  in  S  target completer index.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_rdata  out  N  read data; 0 for writes, errors and timeouts.
rsp_slverr  out  1  transfer failed (pslverr, bad select or timeout).
rsp_timeout  out  1  failure caused by timeout.
paddr  out  A  APB address.
pprot  out  3  APB protection.
pselx  out  O  one-hot APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  N  APB write data.
pstrb  out  B  APB write strobes.
pready  in  1  completer ready.
prdata  in  N  completer read data.
pslverr  in  1  completer error.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. All outputs 0, including cmd_ready, rsp_valid, pselx and penable. Wait counter cleared.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1.
  - On accept, register addr/write/wdata/strb/prot/sel.
  - If sel<O: go to SETUP.
  - If sel>=O: go to RESP with rsp_slverr=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
- SETUP (1 cycle): pselx[sel]=1, penable=0, APB outputs driven from registers.
  - Reads: pwdata=0, pstrb=0.
  - Always go to ACCESS.
- ACCESS: pselx held, penable=1, all APB outputs stable. Wait counter increments each cycle with pready=0.
  - pready=1: capture pslverr; capture prdata for reads only (0 for writes, and 0 if pslverr=1). Drop pselx/penable. Go to RESP.
  - pready=0 and T>0 and counter==T: abandon the transfer. Drop pselx/penable, set rsp_slverr=1 and rsp_timeout=1. Go to RESP.
  - With T=16, up to 16 wait states are tolerated; the 17th cycle without pready times out. pready arriving on that same cycle wins.
- RESP: rsp_valid=1, response fields held stable until rsp_ready. On handshake go to IDLE; rsp_valid drops the next cycle.
- cmd_ready=0 in SETUP, ACCESS and RESP. One outstanding transfer at a time.
- Latency with zero wait states:
  - accept at cycle 0;
  - SETUP at cycle 1;
  - ACCESS at cycle 2;
  - rsp_valid at cycle 3.
  - Minimum command-to-command spacing is 4 cycles.
- pready, prdata and pslverr are ignored outside ACCESS.
- Wait counter width is $clog2(T+1). It is cleared on entry to SETUP.
- presetn asserted mid-transfer: pselx and penable drop immediately (asynchronously). The command and any pending response are discarded. No response is produced for it.

Test Plan:
1. Write, addr=0x004, wdata=0xDEADBEEF, strb=4'hF, pready=1 in the first ACCESS cycle -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with rdata=0, slverr=0.
2. Read, addr=0x008, pready held low for 3 ACCESS cycles then high with prdata=0x12345678 -> penable high for 4 cycles, pwdata=0 and pstrb=0 throughout, rsp_rdata=0x12345678.
3. Write with pslverr=1 alongside pready -> rsp_slverr=1, rsp_timeout=0; then hold rsp_ready=0 for 5 cycles -> rsp_valid and fields stable, cmd_ready=0 for those cycles.
4. T=16, pready never asserted -> after 17 ACCESS cycles pselx/penable drop, rsp_slverr=1, rsp_timeout=1. Repeat with pready on the 17th cycle -> normal response.
5. O=2, cmd_sel=2 (O=2 gives S=1, so use O=3, cmd_sel=3) -> no pselx activity, rsp_valid at cycle 1 with slverr=1, timeout=0.
6. presetn low during an ACCESS wait state -> pselx, penable and rsp_valid are 0 within the same cycle. After release, cmd_ready=1 and a new read completes normally.
